// File: rtl/ddr_arbiter.sv
// ddr_arbiter
//   Shares one DDR port between an instruction-fetch requester (8-entry
//   burst reads) and a load/store unit (single-entry reads and masked
//   writes).  Round-robin arbitration, one operation in flight at a time.
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   fetch_req/fetch_addr      : fetch request and word address
//   fetch_resp_valid/_data    : one-cycle response pulse, 8 x 64-bit burst
//   lsu_req/_we/_addr/_wdata/_wmask : LSU request and write payload
//   lsu_resp_valid/_rdata     : one-cycle response pulse, 64-bit read data
//   ddr_*  (outputs)          : latched DDR command, chip enable
//   ddr_fetch_burst_read_inst, ddr_access_read_data, ddr_ready : DDR returns
//   err_timeout               : sticky flag, an operation waited TIMEOUT cycles
module ddr_arbiter #(
  parameter int TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_req,
  input  logic [18:0]  fetch_addr,
  output logic         fetch_resp_valid,
  output logic [511:0] fetch_resp_data,
  input  logic         lsu_req,
  input  logic         lsu_we,
  input  logic [18:0]  lsu_addr,
  input  logic [63:0]  lsu_wdata,
  input  logic [63:0]  lsu_wmask,
  output logic         lsu_resp_valid,
  output logic [63:0]  lsu_resp_rdata,
  output logic         ddr_chip_enable,
  output logic         ddr_write_enable,
  output logic         ddr_burst_mode,
  output logic [18:0]  ddr_address,
  output logic [63:0]  ddr_access_write_data,
  output logic [63:0]  ddr_access_write_mask,
  output logic [511:0] ddr_l2_burst_write_data,
  input  logic [511:0] ddr_fetch_burst_read_inst,
  input  logic [63:0]  ddr_access_read_data,
  input  logic         ddr_ready,
  output logic         err_timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_LSU   = 1'b1;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]   state_reg;
  logic         grant_lsu_reg;   // owner of the operation in flight
  logic         last_grant_reg;  // owner of the most recent grant
  logic [7:0]   busy_cnt_reg;
  logic         err_reg;
  logic         we_reg;
  logic         burst_reg;
  logic [18:0]  addr_reg;
  logic [63:0]  wdata_reg;
  logic [63:0]  wmask_reg;
  logic [511:0] fetch_data_reg;
  logic [63:0]  lsu_data_reg;

  logic         any_req;
  logic         pick_lsu;
  logic [7:0]   busy_inc;

  // Burst fetches are always 8-entry aligned, so the low address bits
  // never reach the DDR.
  logic unused_fetch_low;
  assign unused_fetch_low = ^fetch_addr[2:0];

  assign any_req = fetch_req | lsu_req;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    pick_lsu = lsu_req;
    if (fetch_req && lsu_req) begin
      pick_lsu = (last_grant_reg == GRANT_FETCH);
    end
  end

  assign busy_inc = (busy_cnt_reg == 8'hFF) ? 8'hFF : busy_cnt_reg + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_lsu_reg  <= GRANT_FETCH;
      last_grant_reg <= GRANT_LSU;
      busy_cnt_reg   <= 8'd0;
      err_reg        <= 1'b0;
      we_reg         <= 1'b0;
      burst_reg      <= 1'b0;
      addr_reg       <= 19'd0;
      wdata_reg      <= 64'd0;
      wmask_reg      <= 64'd0;
      fetch_data_reg <= 512'd0;
      lsu_data_reg   <= 64'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg      <= BUSY;
            grant_lsu_reg  <= pick_lsu;
            last_grant_reg <= pick_lsu;
            busy_cnt_reg   <= 8'd0;
            if (pick_lsu) begin
              we_reg    <= lsu_we;
              burst_reg <= 1'b0;
              addr_reg  <= lsu_addr;
              wdata_reg <= lsu_wdata;
              wmask_reg <= lsu_wmask;
            end else begin
              // Write data/mask are meaningless for a burst read and are
              // left holding the last LSU payload.
              we_reg    <= 1'b0;
              burst_reg <= 1'b1;
              addr_reg  <= {fetch_addr[18:3], 3'b000};
            end
          end
        end
        BUSY: begin
          busy_cnt_reg <= busy_inc;
          if (ddr_ready) begin
            state_reg <= RESP;
            if (grant_lsu_reg == GRANT_FETCH) begin
              fetch_data_reg <= ddr_fetch_burst_read_inst;
            end else if (!we_reg) begin
              lsu_data_reg <= ddr_access_read_data;
            end
          end else if (busy_inc >= TIMEOUT_CNT) begin
            // Flag only; the operation keeps waiting for ddr_ready.
            err_reg <= 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Enable drops combinationally while ready is high so the DDR never
  // sees a request on the cycle it completes the previous one.
  assign ddr_chip_enable         = (state_reg == BUSY) && !ddr_ready;
  assign ddr_write_enable        = we_reg;
  assign ddr_burst_mode          = burst_reg;
  assign ddr_address             = addr_reg;
  assign ddr_access_write_data   = wdata_reg;
  assign ddr_access_write_mask   = wmask_reg;
  assign ddr_l2_burst_write_data = 512'd0;

  assign fetch_resp_valid = (state_reg == RESP) && (grant_lsu_reg == GRANT_FETCH);
  assign lsu_resp_valid   = (state_reg == RESP) && (grant_lsu_reg == GRANT_LSU);
  assign fetch_resp_data  = fetch_data_reg;
  assign lsu_resp_rdata   = lsu_data_reg;
  assign err_timeout      = err_reg;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Testbench for ddr_arbiter: DDR memory model, two queue-driven requesters,
// a transaction-level reference model compared against the DUT every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_ddr_arbiter;

  localparam int TIMEOUT = 200;

  logic         clk;
  logic         rst;
  logic         fetch_req;
  logic [18:0]  fetch_addr;
  logic         fetch_resp_valid;
  logic [511:0] fetch_resp_data;
  logic         lsu_req;
  logic         lsu_we;
  logic [18:0]  lsu_addr;
  logic [63:0]  lsu_wdata;
  logic [63:0]  lsu_wmask;
  logic         lsu_resp_valid;
  logic [63:0]  lsu_resp_rdata;
  logic         ddr_chip_enable;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [18:0]  ddr_address;
  logic [63:0]  ddr_access_write_data;
  logic [63:0]  ddr_access_write_mask;
  logic [511:0] ddr_l2_burst_write_data;
  logic [511:0] ddr_fetch_burst_read_inst;
  logic [63:0]  ddr_access_read_data;
  logic         ddr_ready;
  logic         err_timeout;

  ddr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .fetch_req                 (fetch_req),
    .fetch_addr                (fetch_addr),
    .fetch_resp_valid          (fetch_resp_valid),
    .fetch_resp_data           (fetch_resp_data),
    .lsu_req                   (lsu_req),
    .lsu_we                    (lsu_we),
    .lsu_addr                  (lsu_addr),
    .lsu_wdata                 (lsu_wdata),
    .lsu_wmask                 (lsu_wmask),
    .lsu_resp_valid            (lsu_resp_valid),
    .lsu_resp_rdata            (lsu_resp_rdata),
    .ddr_chip_enable           (ddr_chip_enable),
    .ddr_write_enable          (ddr_write_enable),
    .ddr_burst_mode            (ddr_burst_mode),
    .ddr_address               (ddr_address),
    .ddr_access_write_data     (ddr_access_write_data),
    .ddr_access_write_mask     (ddr_access_write_mask),
    .ddr_l2_burst_write_data   (ddr_l2_burst_write_data),
    .ddr_fetch_burst_read_inst (ddr_fetch_burst_read_inst),
    .ddr_access_read_data      (ddr_access_read_data),
    .ddr_ready                 (ddr_ready),
    .err_timeout               (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_lsu;
    logic        we;
    logic [18:0] addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } txn_t;

  typedef struct packed {
    logic        we;
    logic        burst;
    logic [18:0] addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
  } cmd_t;

  localparam int ST_IDLE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_RESP = 2;

  int n_checks = 0;
  int n_pass   = 0;

  // requester queues
  txn_t fq[$];
  txn_t lq[$];

  // DDR environment
  logic [63:0] ddr_mem [logic [18:0]];
  int          ddr_latency;
  int          ddr_seen;

  // reference model
  logic [63:0]  gold_mem [logic [18:0]];
  int           m_stage;
  txn_t         m_cur;
  logic         m_last_lsu;
  int           m_wait;
  logic         m_err;
  cmd_t         m_cmd;
  logic [511:0] m_fetch_data;
  logic [63:0]  m_lsu_data;

  // observation
  int          n_fetch_pulse;
  int          n_lsu_pulse;
  int          n_ce_overlap;
  int          grant_log[$];
  logic        cap_valid;
  logic [18:0] cap_addr;
  logic        cap_burst;
  logic        rst_next;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] pattern(input logic [18:0] a);
    return {13'h1ABC, a, 13'h0F0F, a};
  endfunction

  function automatic logic [63:0] ddr_rd(input logic [18:0] a);
    return ddr_mem.exists(a) ? ddr_mem[a] : pattern(a);
  endfunction

  function automatic logic [63:0] gold_rd(input logic [18:0] a);
    return gold_mem.exists(a) ? gold_mem[a] : pattern(a);
  endfunction

  function automatic txn_t mk_fetch(input logic [18:0] a);
    txn_t t;
    t = '0;
    t.addr = a;
    return t;
  endfunction

  function automatic txn_t mk_lsu(input logic we, input logic [18:0] a,
                                  input logic [63:0] d, input logic [63:0] m);
    txn_t t;
    t.is_lsu = 1'b1;
    t.we     = we;
    t.addr   = a;
    t.wdata  = d;
    t.wmask  = m;
    return t;
  endfunction

  task automatic model_reset();
    m_stage      = ST_IDLE;
    m_cur        = '0;
    m_last_lsu   = 1'b1;
    m_wait       = 0;
    m_err        = 1'b0;
    m_cmd        = '0;
    m_fetch_data = '0;
    m_lsu_data   = '0;
  endtask

  // Advance the reference model across one rising edge.
  task automatic model_step();
    logic [18:0] a;
    case (m_stage)
      ST_IDLE: begin
        if (fetch_req || lsu_req) begin
          if (fetch_req && lsu_req) m_cur.is_lsu = !m_last_lsu;
          else                      m_cur.is_lsu = lsu_req;
          m_last_lsu = m_cur.is_lsu;
          if (m_cur.is_lsu) begin
            m_cur = mk_lsu(lsu_we, lsu_addr, lsu_wdata, lsu_wmask);
            m_cmd = '{we: lsu_we, burst: 1'b0, addr: lsu_addr, wdata: lsu_wdata, wmask: lsu_wmask};
          end else begin
            m_cur = mk_fetch({fetch_addr[18:3], 3'b000});
            m_cmd.we    = 1'b0;
            m_cmd.burst = 1'b1;
            m_cmd.addr  = m_cur.addr;
          end
          m_stage = ST_BUSY;
          m_wait  = 0;
        end
      end
      ST_BUSY: begin
        if (ddr_ready) begin
          if (!m_cur.is_lsu) begin
            for (int i = 0; i < 8; i++) begin
              a = m_cur.addr + 19'(i);
              m_fetch_data[i*64 +: 64] = gold_rd(a);
            end
          end else if (m_cur.we) begin
            gold_mem[m_cur.addr] = (gold_rd(m_cur.addr) & ~m_cur.wmask) | (m_cur.wdata & m_cur.wmask);
          end else begin
            m_lsu_data = gold_rd(m_cur.addr);
          end
          m_stage = ST_RESP;
        end else begin
          m_wait++;
          if (m_wait >= TIMEOUT) m_err = 1'b1;
        end
      end
      default: m_stage = ST_IDLE;
    endcase
  endtask

  task automatic compare();
    check("ddr_chip_enable",  ddr_chip_enable,  (m_stage == ST_BUSY) && !ddr_ready);
    check("ddr_write_enable", ddr_write_enable, m_cmd.we);
    check("ddr_burst_mode",   ddr_burst_mode,   m_cmd.burst);
    check("ddr_address",      ddr_address,      m_cmd.addr);
    check("ddr_wdata",        ddr_access_write_data, m_cmd.wdata);
    check("ddr_wmask",        ddr_access_write_mask, m_cmd.wmask);
    check("ddr_l2_wdata",     ddr_l2_burst_write_data, 512'd0);
    check("fetch_resp_valid", fetch_resp_valid, (m_stage == ST_RESP) && !m_cur.is_lsu);
    check("lsu_resp_valid",   lsu_resp_valid,   (m_stage == ST_RESP) && m_cur.is_lsu);
    check("fetch_resp_data",  fetch_resp_data,  m_fetch_data);
    check("lsu_resp_rdata",   lsu_resp_rdata,   m_lsu_data);
    check("err_timeout",      err_timeout,      m_err);
  endtask

  // One clock: drive at the falling edge, compare, then account for the
  // coming rising edge.
  task automatic cycle();
    logic [18:0] a;
    @(negedge clk);
    rst = rst_next;
    if (rst) begin
      ddr_ready = 1'b0;
      ddr_seen  = 0;
    end else if (ddr_ready) begin
      ddr_ready = 1'b0;
    end else if (ddr_seen >= ddr_latency) begin
      ddr_ready = 1'b1;
      ddr_seen  = 0;
      ddr_access_read_data = ddr_rd(ddr_address);
      for (int i = 0; i < 8; i++) begin
        a = ddr_address + 19'(i);
        ddr_fetch_burst_read_inst[i*64 +: 64] = ddr_rd(a);
      end
      if (ddr_write_enable)
        ddr_mem[ddr_address] = (ddr_rd(ddr_address) & ~ddr_access_write_mask)
                             | (ddr_access_write_data & ddr_access_write_mask);
    end
    fetch_req = (fq.size() != 0);
    if (fetch_req) fetch_addr = fq[0].addr;
    lsu_req = (lq.size() != 0);
    if (lsu_req) begin
      lsu_we    = lq[0].we;
      lsu_addr  = lq[0].addr;
      lsu_wdata = lq[0].wdata;
      lsu_wmask = lq[0].wmask;
    end
    #1;
    compare();
    if (ddr_chip_enable) ddr_seen++;
    if (ddr_chip_enable && !cap_valid) begin
      cap_valid = 1'b1;
      cap_addr  = ddr_address;
      cap_burst = ddr_burst_mode;
    end
    if (ddr_chip_enable && (ddr_ready || fetch_resp_valid || lsu_resp_valid)) n_ce_overlap++;
    if (fetch_resp_valid) begin
      n_fetch_pulse++;
      grant_log.push_back(0);
      if (fq.size() != 0) void'(fq.pop_front());
    end
    if (lsu_resp_valid) begin
      n_lsu_pulse++;
      grant_log.push_back(1);
      if (lq.size() != 0) void'(lq.pop_front());
    end
    if (rst) model_reset();
    else     model_step();
  endtask

  task automatic drain(input int max_cycles, input string what);
    int n;
    n = 0;
    while ((fq.size() != 0 || lq.size() != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    check({what, " completes in budget"}, (fq.size() == 0) && (lq.size() == 0), 1'b1);
    cycle();
    cycle();
  endtask

  task automatic clear_obs();
    n_fetch_pulse = 0;
    n_lsu_pulse   = 0;
    n_ce_overlap  = 0;
    cap_valid     = 1'b0;
    grant_log.delete();
  endtask

  initial begin
    int n;
    int exp_order[4];
    rst = 1'b1;
    rst_next = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    ddr_ready = 1'b0; ddr_access_read_data = '0; ddr_fetch_burst_read_inst = '0;
    ddr_latency = 3;
    ddr_seen = 0;
    model_reset();
    clear_obs();

    // reset state
    repeat (3) cycle();
    rst_next = 1'b0;
    cycle();
    check("reset chip_enable", ddr_chip_enable, 1'b0);
    check("reset err_timeout", err_timeout, 1'b0);
    check("reset fetch_resp_data", fetch_resp_data, 512'd0);
    repeat (2) cycle();

    // fetch only, unaligned address
    clear_obs();
    fq.push_back(mk_fetch(19'h00105));
    drain(50, "fetch");
    check("fetch ddr_address aligned", cap_addr, 19'h00100);
    check("fetch burst_mode", cap_burst, 1'b1);
    check("fetch pulse count", n_fetch_pulse, 1);
    check("fetch lane0", fetch_resp_data[63:0], 64'hD5E00100_78780100);
    check("fetch lane7", fetch_resp_data[511:448], 64'hD5E00107_78780107);

    // LSU write then read back
    clear_obs();
    ddr_latency = 5;
    lq.push_back(mk_lsu(1'b1, 19'h00020, 64'hDEAD_BEEF_0000_0001, {64{1'b1}}));
    lq.push_back(mk_lsu(1'b0, 19'h00020, 64'd0, 64'd0));
    drain(80, "lsu write/read");
    check("lsu readback", lsu_resp_rdata, 64'hDEAD_BEEF_0000_0001);
    check("lsu pulse count", n_lsu_pulse, 2);
    check("lsu fetch pulses", n_fetch_pulse, 0);

    // both requesting continuously
    clear_obs();
    ddr_latency = 2;
    fq.push_back(mk_fetch(19'h00200));
    fq.push_back(mk_fetch(19'h00308));
    lq.push_back(mk_lsu(1'b0, 19'h00020, 64'd0, 64'd0));
    lq.push_back(mk_lsu(1'b1, 19'h00040, 64'h0000_0000_1234_5678, 64'h0000_0000_FFFF_FFFF));
    drain(120, "round robin");
    exp_order = '{0, 1, 0, 1};
    check("grant count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("grant order %0d", i), grant_log[i], exp_order[i]);
    check("chip_enable on ready/resp", n_ce_overlap, 0);
    check("rr lsu read data", lsu_resp_rdata, 64'hDEAD_BEEF_0000_0001);

    // timeout: ready withheld for 250 cycles
    clear_obs();
    ddr_latency = 250;
    lq.push_back(mk_lsu(1'b0, 19'h00030, 64'd0, 64'd0));
    n = 0;
    while (lq.size() != 0 && n < 400) begin
      cycle();
      n++;
      if (ddr_seen == 199 || ddr_seen == 200) begin
        @(posedge clk);
        #1;
        check($sformatf("err_timeout after %0d busy cycles", ddr_seen), err_timeout, ddr_seen >= 200);
      end
    end
    check("timeout op completes", lq.size(), 0);
    repeat (3) cycle();
    check("err_timeout sticky", err_timeout, 1'b1);
    check("timeout read data", lsu_resp_rdata, 64'hD5E00030_78780030);
    check("timeout lsu pulses", n_lsu_pulse, 1);

    // asynchronous reset in the middle of a fetch burst
    clear_obs();
    ddr_latency = 100;
    fq.push_back(mk_fetch(19'h00400));
    n = 0;
    while (ddr_seen < 30 && n < 60) begin
      cycle();
      n++;
    end
    check("reached 30 busy cycles", ddr_seen, 30);
    @(negedge clk);
    #2;
    rst = 1'b1;
    rst_next = 1'b1;
    ddr_ready = 1'b0;
    ddr_seen = 0;
    fq.delete();
    fetch_req = 1'b0;
    #1;
    model_reset();
    compare();
    check("async rst chip_enable", ddr_chip_enable, 1'b0);
    check("async rst err_timeout", err_timeout, 1'b0);
    check("async rst ddr_address", ddr_address, 19'd0);
    check("async rst lsu_resp_rdata", lsu_resp_rdata, 64'd0);
    repeat (2) cycle();
    rst_next = 1'b0;
    repeat (4) cycle();
    check("no fetch resp after reset", n_fetch_pulse, 0);
    ddr_latency = 4;
    lq.push_back(mk_lsu(1'b0, 19'h00020, 64'd0, 64'd0));
    drain(40, "post-reset lsu");
    check("post-reset lsu data", lsu_resp_rdata, 64'hDEAD_BEEF_0000_0001);
    check("post-reset lsu pulses", n_lsu_pulse, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
